// File: rtl/flash_boot_pkg.sv
// Shared definitions for the flash boot controller: state encoding and default
// reset-hold length of the RELEASE phase.
package flash_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam int REL_CYC_DEF = 16;

endpackage

// File: rtl/flash_boot_packer.sv
// Byte-to-word assembler for the boot stream. Bytes pack little-endian; a
// completed word stays pending (and the stream stalls) until the owner takes it.
module flash_boot_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        word_take,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  lane_q;
  logic [23:0] acc_q;
  logic [31:0] word_q;
  logic        pend_q;
  logic        accept;

  // Never advertise ready in a cycle whose byte would be thrown away by clear.
  assign ld_ready   = enable & ~pend_q & ~clear;
  assign accept     = ld_valid & ld_ready;
  assign word_valid = pend_q;
  assign word_data  = word_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= '0;
      acc_q  <= '0;
      word_q <= '0;
      pend_q <= 1'b0;
    end else if (clear) begin
      lane_q <= '0;
      pend_q <= 1'b0;
    end else begin
      if (word_take) pend_q <= 1'b0;
      if (accept) begin
        lane_q <= lane_q + 2'd1;
        case (lane_q)
          2'd0:    acc_q[7:0]   <= ld_data;
          2'd1:    acc_q[15:8]  <= ld_data;
          2'd2:    acc_q[23:16] <= ld_data;
          default: begin
            word_q <= {ld_data, acc_q};
            pend_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/flash_boot_ctrl.sv
// Boot controller: streams an image into emulator memory, holds the DUT in reset,
// releases it and optionally watches it. Macro FLASH_BOOT_WDOG_EN enables the watchdog.
module flash_boot_ctrl
  import flash_boot_pkg::*;
#(
  parameter int TMO_W   = 24,
  parameter int REL_CYC = REL_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctl_start,
  input  logic        ctl_abort,
  input  logic [15:0] ld_base,
  input  logic [15:0] ld_len,
  input  logic [7:0]  ld_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [15:0] host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic        host_wr_req,
  output logic        host_wr_gnt,
  output logic [15:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_wr_ena,
  input  logic        mon_stb,
  output logic        dut_rst_n,
  output logic [2:0]  status_state,
  output logic        status_fault
);

  localparam int REL_W = (REL_CYC > 1) ? $clog2(REL_CYC) : 1;

  state_t           state_q, state_d;
  logic [15:0]      base_q, len_q, word_cnt_q;
  logic [REL_W-1:0] rel_cnt_q;
  logic             dut_rst_q;
  logic             start_go, pk_clear, ld_issue, last_word, rel_done, wd_expire;
  logic             word_valid;
  logic [31:0]      word_data;

  // Handshakes: a stream byte transfers on a rising edge where ld_valid & ld_ready;
  // a host write transfers on a rising edge where host_wr_gnt is high, and the host
  // keeps host_wr_req/addr/data stable until then. Host always beats the loader.
  assign host_wr_gnt = host_wr_req & rst_n;
  assign start_go    = ctl_start & ~ctl_abort & ((state_q == ST_IDLE) | (state_q == ST_FAULT));
  assign pk_clear    = ctl_abort | start_go;
  assign ld_issue    = (state_q == ST_LOAD) & word_valid & ~host_wr_req & ~ctl_abort;
  assign last_word   = (word_cnt_q + 16'd1) == len_q;
  assign rel_done    = (state_q == ST_RELEASE) && (rel_cnt_q == REL_W'(REL_CYC - 1));

  flash_boot_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .enable     (state_q == ST_LOAD),
    .ld_data    (ld_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .word_take  (ld_issue),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_FAULT: if (ctl_start) state_d = (ld_len == 16'd0) ? ST_RELEASE : ST_LOAD;
      ST_LOAD:           if (ld_issue && last_word) state_d = ST_RELEASE;
      ST_RELEASE:        if (rel_done) state_d = ST_RUN;
      ST_RUN:            if (wd_expire) state_d = ST_FAULT;
      default:           state_d = ST_IDLE;
    endcase
    if (ctl_abort) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dut_rst_q   <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      rel_cnt_q   <= '0;
      mem_wr_ena  <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else begin
      state_q   <= state_d;
      dut_rst_q <= (state_d == ST_RUN);
      if (start_go) begin
        base_q     <= ld_base;
        len_q      <= ld_len;
        word_cnt_q <= '0;
      end else if (ld_issue) begin
        word_cnt_q <= word_cnt_q + 16'd1;
      end
      rel_cnt_q  <= (state_q == ST_RELEASE) ? rel_cnt_q + 1'b1 : '0;
      mem_wr_ena <= host_wr_gnt | ld_issue;
      if (host_wr_gnt) begin
        mem_wr_addr <= host_wr_addr;
        mem_wr_data <= host_wr_data;
      end else if (ld_issue) begin
        mem_wr_addr <= base_q + word_cnt_q;
        mem_wr_data <= word_data;
      end
    end
  end

  assign dut_rst_n    = dut_rst_q;
  assign status_state = state_q;

`ifdef FLASH_BOOT_WDOG_EN
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] wd_q;
  logic             fault_q;

  // The counter reaches all-ones on the same edge that enters FAULT.
  assign wd_expire = (state_q == ST_RUN) && !mon_stb && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q <= ((state_q == ST_RUN) && !mon_stb) ? wd_q + 1'b1 : '0;
      if (start_go) fault_q <= 1'b0;
      else if ((state_q == ST_RUN) && (state_d == ST_FAULT)) fault_q <= 1'b1;
    end
  end

  assign status_fault = fault_q;
`else
  logic unused_wdog;
  assign unused_wdog  = mon_stb & (TMO_W > 0);
  assign wd_expire    = 1'b0;
  assign status_fault = 1'b0;
`endif

endmodule

// File: doc/flash_boot_ctrl.md
FLASH_BOOT_CTRL -- requirements
Module: flash_boot_ctrl

Interface
REQ-001 Parameter TMO_W, default 24, watchdog counter width; timeout = 2^TMO_W-1 cycles.
REQ-002 Parameter REL_CYC, default 16, reset-hold cycles in RELEASE.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 ctl_start  in  1  one-cycle pulse that starts a boot sequence.
REQ-006 ctl_abort  in  1  one-cycle pulse that forces a return to IDLE.
REQ-007 ld_base  in  16  first word address for the stream load.
REQ-008 ld_len  in  16  number of 32-bit words to load.
REQ-009 ld_data  in  8  stream byte.
REQ-010 ld_valid  in  1  stream byte valid.
REQ-011 ld_ready  out  1  stream byte accepted when ld_valid & ld_ready.
REQ-012 host_wr_addr  in  16  host word address.
REQ-013 host_wr_data  in  32  host word data.
REQ-014 host_wr_req  in  1  host write request, held until granted.
REQ-015 host_wr_gnt  out  1  one-cycle grant; host write is taken this cycle.
REQ-016 mem_wr_addr / mem_wr_data / mem_wr_ena  out  16/32/1  registered emulator memory write port.
REQ-017 mon_stb  in  1  emulator command-decoded strobe.
REQ-018 dut_rst_n  out  1  DUT reset, active low.
REQ-019 status_state  out  3  current state encoding.
REQ-020 status_fault  out  1  sticky watchdog fault flag.

Function
REQ-021 States SHALL be IDLE, LOAD, RELEASE, RUN and FAULT; dut_rst_n SHALL be 0 in every state except RUN.
REQ-022 IDLE + ctl_start SHALL go to LOAD, clearing the word counter and byte lane; when ld_len=0 it SHALL go directly to RELEASE.
REQ-023 LOAD SHALL pack bytes little-endian (first byte to [7:0]) and write the word at (ld_base + word_cnt) mod 2^16.
REQ-024 ld_ready SHALL be 1 only in LOAD while no completed word is pending.
REQ-025 A host request SHALL win over a pending loader word in the same cycle; the loader word SHALL be held and ld_ready SHALL stay 0 until it is written.
REQ-026 Host writes SHALL be granted in all states.
REQ-027 mem_wr_ena SHALL pulse exactly 1 cycle after each grant or loader word issue, with the matching address and data.
REQ-028 After word ld_len is written, the block SHALL enter RELEASE, hold for REL_CYC cycles, then enter RUN.
REQ-029 In RUN, the watchdog SHALL clear on each mon_stb and increment otherwise; at all-ones it SHALL enter FAULT and set status_fault.
REQ-030 FAULT SHALL hold the DUT in reset; ctl_start SHALL clear status_fault and go to LOAD.
REQ-031 ctl_abort SHALL take the block to IDLE from any state, discarding a partial word; abort has priority over a simultaneous start.

Reset
REQ-032 On rst_n=0 the block SHALL be in IDLE, with dut_rst_n=0, ld_ready=0, host_wr_gnt=0, mem_wr_ena=0, mem_wr_addr=0, mem_wr_data=0, status_fault=0 and all counters 0.

Configuration
REQ-033 With FLASH_BOOT_WDOG_EN defined, the watchdog and FAULT entry SHALL be present; without it, RUN SHALL exit only on ctl_abort, and status_fault SHALL be tied to 0.

Structure
REQ-034 Package flash_boot_pkg SHALL hold the state encoding and the default REL_CYC value.
REQ-035 A sub-module flash_boot_packer SHALL perform byte-to-word assembly and own the pending-word handshake.

Verification
REQ-036 ld_base=0xFFFE, ld_len=3, bytes 00..0B -> words 0x03020100@FFFE, 0x07060504@FFFF, 0x0B0A0908@0000; then RELEASE for 16 cycles; then dut_rst_n=1.
REQ-037 Host request in the same cycle as a completed loader word -> host word is written first, the loader word follows the next cycle, and ld_ready=0 in between.
REQ-038 ctl_start with ld_len=0 -> no memory writes; dut_rst_n rises REL_CYC cycles later.
REQ-039 With FLASH_BOOT_WDOG_EN and TMO_W=4 in RUN with no mon_stb -> FAULT after 15 cycles, dut_rst_n=0 and status_fault=1; with mon_stb every 10 cycles -> no fault.
REQ-040 ctl_abort after 2 of 4 bytes -> IDLE; a restart loads the correct words with no stale bytes.
REQ-041 rst_n asserted mid-LOAD -> all outputs at their reset values immediately (asynchronously).
